mult_booth_ctrl: RTL
====================

MULT_BOOTH_CTRL -- requirements
Module: mult_booth_ctrl

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits.
REQ-002 clock  input  1  single clock for the block; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ctrl_MULT  input  1  start pulse; sampled every rising edge.
REQ-005 data_operandA  input  32  multiplicand, two's complement; sampled only on the start edge.
REQ-006 data_operandB  input  32  multiplier, two's complement; sampled only on the start edge.
REQ-007 data_result  output  32  low 32 bits of the signed product; registered.
REQ-008 data_exception  output  1  signed overflow flag; registered, valid with data_result.
REQ-009 data_resultRDY  output  1  one-cycle completion pulse.
REQ-010 busy  output  1  high while a multiply is in progress.

Function
REQ-011 The block SHALL compute A*B by radix-2 Booth: a 65-bit register {HI[31:0], LO[31:0], Q-1}, a latched multiplicand M and a 6-bit step counter.
REQ-012 Every Booth add or subtract SHALL go through exactly one instance of the team's 32-bit carry-look-ahead adder.
REQ-013 Add uses HI + M with carry_in=0; subtract uses HI + ~M with carry_in=1; the adder is never instantiated twice.
REQ-014 States SHALL be IDLE, RUN and DONE.
REQ-015 IDLE or DONE with ctrl_MULT=1 at edge E0: load HI=0, LO=B, Q-1=0, M=A, count=0; go to RUN.
REQ-016 On each RUN edge, the block SHALL select the operation from {LO[0], Q-1}: 01 add, 10 subtract, 00 or 11 no-op. It SHALL then arithmetic-shift the 65-bit register right by 1 (sign taken from the 33-bit extended adder result) and increment count.
REQ-017 On the 32nd RUN edge (E32), the block SHALL update data_result=LO (post-shift), set data_exception, set data_resultRDY=1 and go to DONE.
REQ-018 Latency: data_resultRDY is high during the cycle after E32, exactly one cycle; DONE returns to IDLE on the next edge unless ctrl_MULT=1.
REQ-019 data_result and data_exception SHALL hold their values from completion until the next completion; they do not change during RUN.
REQ-020 busy SHALL be 1 exactly while the state is RUN.
REQ-021 ctrl_MULT=1 during RUN SHALL abort the current operation and restart with the new operands (same load as REQ-015); the aborted operation produces no data_resultRDY.
REQ-022 ctrl_MULT=1 in DONE SHALL start a new operation on that edge; data_resultRDY still pulses for the finished one.
REQ-023 Operand changes outside the start edge SHALL have no effect.

Reset
REQ-024 When reset=1 at a rising edge, the block SHALL go to IDLE and clear data_result=0, data_exception=0, data_resultRDY=0, busy=0, count=0 and all internal registers.
REQ-025 reset SHALL take priority over ctrl_MULT and over completion on the same edge.
REQ-026 Reset during RUN SHALL abort the operation with no data_resultRDY pulse.

Configuration
REQ-027 Macro MULT_OVERFLOW_EN: when defined, data_exception=1 iff the 64-bit product's bits [63:31] are not all equal (the product does not fit in signed 32 bits).
REQ-028 Without MULT_OVERFLOW_EN, data_exception SHALL be constant 0 and no overflow logic is synthesized; all other behaviour is unchanged.

Verification
REQ-029 Reset, then A=3, B=5, ctrl_MULT pulse at E0 -> data_resultRDY high only after E32, data_result=15, data_exception=0, busy high E1..E32.
REQ-030 A=-7 (0xFFFFFFF9), B=6 -> data_result=0xFFFFFFD6 (-42), exception 0.
REQ-031 A=0x00010000, B=0x00010000 -> data_result=0. Exception is 1 with MULT_OVERFLOW_EN and 0 without.
REQ-032 A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000. Exception is 1 with MULT_OVERFLOW_EN.
REQ-033 Start 3*5, then at E10 ctrl_MULT with A=2, B=9 -> single RDY pulse 32 edges after E10, data_result=18; no pulse for the aborted 3*5.
REQ-034 Start 3*5, reset=1 at E20 together with ctrl_MULT=1 -> IDLE, all outputs 0, no RDY pulse; next start computes correctly.

Source files
------------

// File: rtl/mult_booth_ctrl_if.sv
// Start/operand/result bundle for the radix-2 Booth multiplier controller.
interface mult_booth_ctrl_if;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/mult_booth_ctrl.sv
// Sequential 32x32 radix-2 Booth multiplier, 32 steps through one shared CLA adder.
// Optional signed-overflow flag enabled by defining MULT_OVERFLOW_EN.
module cla_adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Carries within each 4-bit group are looked ahead from the group's carry-in.
  always_comb begin
    // NOTE: every bit gets a default before the loop so no latch is inferred.
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign sum  = p ^ c[31:0];
  assign cout = c[32];
endmodule

module mult_booth_ctrl (
  input  logic              clock,
  input  logic              reset,
  mult_booth_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        q;
  logic [31:0] m;
  logic [5:0]  count;
  logic [31:0] result;

  logic        do_add;
  logic        do_sub;
  logic [31:0] addend;
  logic [31:0] sum;
  logic        cout;
  logic [32:0] ext;
  logic [31:0] hi_n;
  logic [31:0] lo_n;
  logic        last_step;

  assign do_add    = ~lo[0] & q;
  assign do_sub    = lo[0] & ~q;
  assign addend    = do_sub ? ~m : m;
  assign last_step = (count == 6'd31);

  cla_adder_32 u_adder (
    .a    (hi),
    .b    (addend),
    .cin  (do_sub),
    .sum  (sum),
    .cout (cout)
  );

  // Bit 32 of the sign-extended sum recovers the true sign when HI+-M overflows 32 bits.
  assign ext  = (do_add || do_sub) ? {hi[31] ^ addend[31] ^ cout, sum} : {hi[31], hi};
  assign hi_n = {ext[32], ext[32:1]};
  assign lo_n = {ext[0], lo[31:1]};

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.ctrl_MULT) state_next = RUN;
      RUN:     if (bus.ctrl_MULT) state_next = RUN;
               else if (last_step) state_next = DONE;
      DONE:    state_next = bus.ctrl_MULT ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy           = (state == RUN);
    bus.data_resultRDY = (state == DONE);
  end

  always_ff @(posedge clock) begin
    // NOTE: reset is synchronous and clears every datapath register, not just the FSM.
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      q      <= 1'b0;
      m      <= '0;
      count  <= '0;
      result <= '0;
    end else if (bus.ctrl_MULT) begin
      hi    <= '0;
      lo    <= bus.data_operandB;
      q     <= 1'b0;
      m     <= bus.data_operandA;
      count <= '0;
    end else if (state == RUN) begin
      hi    <= hi_n;
      lo    <= lo_n;
      q     <= lo[0];
      count <= count + 6'd1;
      if (last_step) result <= lo_n;
    end
  end

  assign bus.data_result = result;

`ifdef MULT_OVERFLOW_EN
  logic [32:0] prod_top;
  logic        exception;

  // Product fits in signed 32 bits only when bits [63:31] are a pure sign extension.
  assign prod_top = {hi_n, lo_n[31]};

  always_ff @(posedge clock) begin
    if (reset) exception <= 1'b0;
    else if (!bus.ctrl_MULT && state == RUN && last_step)
      exception <= ~((&prod_top) | ~(|prod_top));
  end

  assign bus.data_exception = exception;
`else
  assign bus.data_exception = 1'b0;
`endif
endmodule
